// File: rtl/j1_uart_iobus.sv
// j1_uart_iobus: J1 IO-bus bridge to NCH byte-stream UART channels, each with an RX FIFO and a one-byte TX holding register
module j1_uart_iobus #(
  parameter int NCH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      dout,
  output logic [15:0]      io_din,
  output logic [NCH-1:0]   tx_valid,
  output logic [8*NCH-1:0] tx_data,
  input  logic [NCH-1:0]   tx_ready,
  input  logic [NCH-1:0]   rx_valid,
  input  logic [8*NCH-1:0] rx_data,
  output logic [NCH-1:0]   rx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic io_rd_, io_wr_;
  logic [15:0] io_addr_, dout_;
  logic [NCH-1:0] sel, nonempty, txovf;
  logic [NCH-1:0][7:0] head;
  logic [NCH-1:0][CW-1:0] count;
  logic unused_bits;
  assign unused_bits = ^{io_addr_[15:14], io_addr_[11:3], io_addr_[0], dout_[15:8]};
  function automatic logic [3:0] rxcnt(input logic [CW-1:0] n);
    return 32'(n) > 15 ? 4'd15 : 4'(n);
  endfunction
  always_ff @(posedge clk) begin
    io_rd_ <= !reset && io_rd;
    io_wr_ <= !reset && io_wr;
    dout_ <= reset ? 16'd0 : dout;
    io_addr_ <= reset ? 16'd0 : (io_rd || io_wr) ? mem_addr : io_addr_;
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic [7:0] td;
    logic tv, ovf, push, pop, dwr, clr, accept;
    assign sel[c] = io_addr_[2:1] == 2'(c);
    assign count[c] = cnt;
    assign nonempty[c] = cnt != '0;
    assign head[c] = mem[rptr];
    assign tx_valid[c] = tv;
    assign tx_data[8*c +: 8] = td;
    assign txovf[c] = ovf;
    assign rx_ready[c] = reset || cnt != CW'(DEPTH);
    assign push = rx_valid[c] && rx_ready[c];
    assign pop = io_rd_ && io_addr_[12] && sel[c] && nonempty[c];
    assign dwr = io_wr_ && io_addr_[12] && sel[c];
    assign clr = io_wr_ && io_addr_[13] && sel[c] && dout_[3];
    // holding register can take a new byte when idle or draining this very cycle
    assign accept = !tv || tx_ready[c];
    always_ff @(posedge clk) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt <= '0;
        tv <= 1'b0;
        td <= 8'd0;
        ovf <= 1'b0;
      end else begin
        if (push) begin
          mem[wptr] <= rx_data[8*c +: 8];
          wptr <= wptr + 1'b1;
        end
        rptr <= rptr + AW'(pop);
        cnt <= cnt + CW'(push) - CW'(pop);
        tv <= (dwr && accept) || (tv && !tx_ready[c]);
        td <= dwr && accept ? dout_[7:0] : td;
        ovf <= (dwr && !accept) || (ovf && !clr);
      end
    end
  end
  // data and status views OR together when both port bits are set
  always_comb begin
    io_din = 16'd0;
    for (int i = 0; i < NCH; i++)
      if (sel[i] && !reset)
        io_din = {8'd0, (io_addr_[12] && nonempty[i] ? head[i] : 8'd0) |
                        (io_addr_[13] ? {rxcnt(count[i]), txovf[i], !tx_valid[i], nonempty[i], 1'b1} : 8'd0)};
  end
endmodule

// File: tb/tb_j1_uart_iobus.sv
// tb_j1_uart_iobus: scoreboard bench for j1_uart_iobus; a queue-based model predicts reads, TX bytes and flow control
module tb_j1_uart_iobus;
  localparam int NCH = 2;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 1, io_rd = 0, io_wr = 0;
  logic [15:0] mem_addr = 0, dout = 0, io_din;
  logic [NCH-1:0] tx_valid, rx_ready, tx_ready = 0, rx_valid = 0;
  logic [8*NCH-1:0] tx_data, rx_data = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] rxq [NCH][$];
  logic [7:0] hold [NCH][$];
  logic [7:0] tx_sb [NCH][$];
  logic [15:0] rd_sb [$];
  logic [NCH-1:0] ovf = 0, exp_rdy = '1, exp_txv = 0, txr = '1;
  logic m_rd = 0, m_wr = 0;
  logic [15:0] m_addr = 0, m_dout = 0;

  j1_uart_iobus #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr), .dout(dout),
    .io_din(io_din), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // what the CPU should see for the address latched by the last strobe
  function automatic logic [15:0] view();
    int ch = int'(m_addr[2:1]);
    logic [7:0] v = 8'd0;
    int n;
    if (ch >= NCH) return 16'd0;
    n = rxq[ch].size();
    if (m_addr[12] && n > 0) v = v | rxq[ch][0];
    if (m_addr[13]) v = v | {4'(n > 15 ? 15 : n), ovf[ch], hold[ch].size() == 0, n > 0, 1'b1};
    return {8'd0, v};
  endfunction

  task automatic model_edge();
    int ch = int'(m_addr[2:1]);
    logic [NCH-1:0] acc;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        rxq[c].delete();
        hold[c].delete();
      end
      ovf = '0; m_rd = 0; m_wr = 0; m_addr = 0; m_dout = 0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      acc[c] = rx_valid[c] && rxq[c].size() != DEPTH;
      if (hold[c].size() > 0 && tx_ready[c]) tx_sb[c].push_back(hold[c].pop_front());
    end
    if (ch < NCH) begin
      if (m_wr && m_addr[13] && m_dout[3]) ovf[ch] = 1'b0;
      if (m_wr && m_addr[12]) begin
        if (hold[ch].size() == 0) hold[ch].push_back(m_dout[7:0]);
        else ovf[ch] = 1'b1;
      end
      if (m_rd && m_addr[12] && rxq[ch].size() > 0) void'(rxq[ch].pop_front());
    end
    for (int c = 0; c < NCH; c++) if (acc[c]) rxq[c].push_back(rx_data[8*c +: 8]);
    m_rd = io_rd;
    m_wr = io_wr;
    m_dout = dout;
    if (io_rd || io_wr) m_addr = mem_addr;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [NCH-1:0] rxv, input logic [8*NCH-1:0] rxd, input logic rst);
    @(negedge clk);
    reset = rst; io_rd = rd; io_wr = wr; mem_addr = a; dout = d;
    rx_valid = rxv; rx_data = rxd; tx_ready = rst ? '0 : txr;
    for (int c = 0; c < NCH; c++) begin
      exp_rdy[c] = rst || rxq[c].size() != DEPTH;
      exp_txv[c] = hold[c].size() > 0;
    end
    if (rst || m_rd) rd_sb.push_back(rst ? 16'd0 : view());
    model_edge();
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    step(rd, wr, a, d, '0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'd0, 16'd0, '0, '0, 1'b0);
  endtask

  task automatic push0(input logic [7:0] b);
    step(1'b0, 1'b0, 16'd0, 16'd0, 2'b01, {8'd0, b}, 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    check("rx_ready", 16'(rx_ready), 16'(exp_rdy));
    check("tx_valid", 16'(tx_valid), 16'(exp_txv));
    if (rd_sb.size() > 0) check("io_din", io_din, rd_sb.pop_front());
    for (int c = 0; c < NCH; c++)
      if (tx_valid[c] && tx_ready[c]) begin
        if (tx_sb[c].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected ch%0d: got byte %h expected no handshake", c, tx_data[8*c +: 8]);
        end else check("tx_data", 16'(tx_data[8*c +: 8]), 16'(tx_sb[c].pop_front()));
      end
  end

  initial begin
    int op, rate;
    logic [15:0] a;
    logic [NCH-1:0] rxv;
    repeat (3) step(1'b0, 1'b0, 16'd0, 16'd0, '0, '0, 1'b1);
    txr = '1;
    cpu(1'b0, 1'b1, 16'h1000, 16'h0041);
    idle(4);
    txr = 2'b01;
    cpu(1'b0, 1'b1, 16'h1002, 16'h0011);
    cpu(1'b0, 1'b1, 16'h1002, 16'h0022);
    idle(1);
    cpu(1'b1, 1'b0, 16'h2002, 16'h0000);
    idle(1);
    txr = '1;
    idle(2);
    cpu(1'b0, 1'b1, 16'h2002, 16'h0008);
    cpu(1'b1, 1'b0, 16'h2002, 16'h0000);
    idle(1);
    for (int i = 0; i < 9; i++) push0(8'(i));
    cpu(1'b1, 1'b0, 16'h2000, 16'h0000);
    idle(1);
    for (int i = 0; i < 8; i++) cpu(1'b1, 1'b0, 16'h1000, 16'h0000);
    idle(1);
    cpu(1'b1, 1'b0, 16'h2000, 16'h0000);
    idle(1);
    for (int i = 0; i < 3; i++) push0(8'h30 + 8'(i));
    cpu(1'b1, 1'b0, 16'h1000, 16'h0000);
    push0(8'h33);
    cpu(1'b1, 1'b0, 16'h3000, 16'h0000);
    for (int i = 0; i < 4; i++) cpu(1'b1, 1'b0, 16'h1000, 16'h0000);
    cpu(1'b1, 1'b0, 16'h1000, 16'h0000);
    cpu(1'b1, 1'b0, 16'h1006, 16'h0000);
    cpu(1'b1, 1'b0, 16'h3006, 16'h0000);
    idle(1);
    for (int i = 0; i < 5; i++) push0(8'h50 + 8'(i));
    txr = '0;
    cpu(1'b0, 1'b1, 16'h1000, 16'h0077);
    idle(3);
    step(1'b0, 1'b0, 16'd0, 16'd0, '0, '0, 1'b1);
    cpu(1'b1, 1'b0, 16'h2000, 16'h0000);
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 7);
      rate = (i / 300) % 2 == 1 ? 15 : 60;
      a = 16'($urandom);
      for (int c = 0; c < NCH; c++) rxv[c] = $urandom_range(0, 99) < rate;
      txr = NCH'($urandom);
      step(op < 3, op == 3 || op == 4, a, 16'($urandom), rxv, (8*NCH)'($urandom), $urandom_range(0, 499) == 0);
    end
    txr = '1;
    idle(5);
    #2;
    for (int c = 0; c < NCH; c++) begin
      n_chk++;
      if (tx_sb[c].size() != 0) begin
        n_fail++;
        $display("FAIL tx_drain ch%0d: %0d bytes never handshaken, expected 0", c, tx_sb[c].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
